// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial packed-BCD add/subtract datapath.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [4:0]  BCD_ADJ = 5'd6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of add/subtract: optional nine's complement of b, binary add with carry,
// then +6 decimal correction when the raw sum exceeds 9.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c_in,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       c_out
);

    logic [3:0] bd;
    logic [4:0] s;

    always_comb begin
        // Nine's complement is a plain 4-bit subtraction, so invalid digits wrap.
        bd = sub ? (BCD_MAX - b_d) : b_d;
        s  = {1'b0, a_d} + {1'b0, bd} + {4'b0000, c_in};
        if (s > {1'b0, BCD_MAX}) begin
            digit = s[3:0] + BCD_ADJ[3:0];
            c_out = 1'b1;
        end else begin
            digit = s[3:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor processing one digit per clock, LSD first,
// with valid/ready handshakes on both sides and invalid-digit flagging.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*DIGITS-1:0]     a,
    input  logic [DIGIT_W*DIGITS-1:0]     b,
    input  logic                          cin,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W*DIGITS-1:0]     sum,
    output logic                          cout,
    output logic                          err
);

    localparam int unsigned W  = DIGIT_W * DIGITS;
    localparam int unsigned IW = $clog2(DIGITS + 1);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res;
    logic [W-1:0]   res_nx;
    logic [IW-1:0]  idx;
    logic           sub_r;
    logic           carry;
    logic           cout_r;
    logic           err_r;
    logic           bad;
    logic           last;
    logic [3:0]     digit;
    logic           c_nx;

    bcd_digit_cell u_cell (
        .a_d   (a_sh[DIGIT_W-1:0]),
        .b_d   (b_sh[DIGIT_W-1:0]),
        .c_in  (carry),
        .sub   (sub_r),
        .digit (digit),
        .c_out (c_nx)
    );

    always_comb begin
        bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (a[k*DIGIT_W +: DIGIT_W] > BCD_MAX || b[k*DIGIT_W +: DIGIT_W] > BCD_MAX)
                bad = 1'b1;
        end
    end

    always_comb begin
        last     = (idx == IW'(DIGITS - 1));
        // New digit enters at the top; after DIGITS shifts digit 0 lands in [3:0].
        res_nx   = W'({digit, res} >> DIGIT_W);
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            idx    <= '0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sub_r <= sub;
                        carry <= sub ? ~cin : cin;
                        err_r <= bad;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    res   <= res_nx;
                    carry <= c_nx;
                    idx   <= idx + IW'(1);
                    if (last)
                        cout_r <= sub_r ? ~c_nx : c_nx;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;
    assign cout      = cout_r;
    assign err       = err_r;

endmodule
